// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } chan_state_t;

  localparam int DIV_MIN = 2;

  // Ratios below DIV_MIN cannot produce a toggling output, so they are raised to DIV_MIN.
  function automatic logic [31:0] clamp_div(input logic [31:0] val);
    return (val < 32'(DIV_MIN)) ? 32'(DIV_MIN) : val;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active ratio, counter, run FSM, registered clock.
// Build option CLK_DIV_ODD_DUTY50_EN adds a negedge stage for 50% duty at odd ratios.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] val,
  input  logic             load,
  input  logic             restart,
  output logic             clk_out,
  output logic             tick,
  output chan_state_t      state
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  chan_state_t      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] shadow_q, shadow_eff;
  logic             pos_q, pos_d;
  logic [DIV_W-1:0] cnt_inc;
  logic             wrap;

  // A load in the same cycle as a load point bypasses straight into the active ratio.
  assign shadow_eff = load ? DIV_W'(clamp_div(32'(val))) : shadow_q;
  assign cnt_inc    = cnt_q + ONE;
  assign wrap       = (cnt_q == n_q - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= DIV_W'(RST_DIV);
      shadow_q <= DIV_W'(RST_DIV);
      pos_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      shadow_q <= shadow_eff;
      pos_q    <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    pos_d   = pos_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pos_d = 1'b0;
        if (en) begin
          state_d = RUN;
          n_d     = shadow_eff;
          pos_d   = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (restart) begin
          cnt_d = '0;
          pos_d = 1'b1;
          n_d   = shadow_eff;
        end else begin
          if (state_q == RUN && !en)  state_d = DRAIN;
          if (state_q == DRAIN && en) state_d = RUN;
          if (wrap) begin
            cnt_d = '0;
            n_d   = shadow_eff;
            pos_d = 1'b1;
            // Draining channel stops only at the end of a full period.
            if (state_q == DRAIN && !en) begin
              state_d = IDLE;
              pos_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_inc;
            pos_d = (cnt_inc < (n_q >> 1));
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pos_d   = 1'b0;
      end
    endcase
  end

  assign tick  = (state_q != IDLE) && wrap;
  assign state = state_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle delayed copy of the high phase, only for odd ratios.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= pos_q & n_q[0];
  end

  assign clk_out = pos_q | neg_q;
`else
  assign clk_out = pos_q;
`endif

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel integer clock divider; one clk_div_chan per channel, shared sync_restart.
// Build option CLK_DIV_ODD_DUTY50_EN enables 50% duty for odd ratios in every channel.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       div_en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running
);

  chan_state_t chan_state [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_div_chan #(
      .DIV_W  (DIV_W),
      .RST_DIV(RST_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (div_en[i]),
      .val    (div_val[i*DIV_W +: DIV_W]),
      .load   (div_load[i]),
      .restart(sync_restart),
      .clk_out(clk_out[i]),
      .tick   (tick[i]),
      .state  (chan_state[i])
    );

    assign running[i] = (chan_state[i] != IDLE);
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: the driver queues the hand-derived per-cycle outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_clk_div_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  div_en;
  logic [15:0] div_val;
  logic [1:0]  div_load;
  logic        sync_restart;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [1:0]  running;

  logic [5:0] exp_q[$];
  int         id_q[$];
  int         errors = 0;
  int         checks = 0;

  wire [5:0] obs = {running[1], tick[1], clk_out[1], running[0], tick[0], clk_out[0]};

  clk_div_gen #(
    .NUM_CH (2),
    .DIV_W  (8),
    .RST_DIV(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_en      (div_en),
    .div_val     (div_val),
    .div_load    (div_load),
    .sync_restart(sync_restart),
    .clk_out     (clk_out),
    .tick        (tick),
    .running     (running)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Expected {running, tick, clk_out} of a running channel at phase c of ratio n.
  function automatic logic [2:0] w(input int c, input int n);
    int hi;
`ifdef CLK_DIV_ODD_DUTY50_EN
    hi = (n + 1) / 2;
`else
    hi = n / 2;
`endif
    return {1'b1, (c == n - 1), (c < hi)};
  endfunction

  task automatic check(input string name, input int id, input logic [5:0] act,
                       input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s test%0d @%0t: got %b expected %b", name, id, $time, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, expectation is for the next rising edge
  task automatic drive(input logic [1:0] en, input logic [7:0] v0, input logic [7:0] v1,
                       input logic [1:0] ld, input logic rs, input logic [2:0] e0,
                       input logic [2:0] e1, input int id);
    @(negedge clk);
    div_en       = en;
    div_val      = {v1, v0};
    div_load     = ld;
    sync_restart = rs;
    exp_q.push_back({e1, e0});
    id_q.push_back(id);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [5:0] e;
      int         id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      check("cycle", id, obs, e);
    end
  end

  initial begin
    rst_n        = 1'b0;
    div_en       = 2'b00;
    div_val      = 16'h0;
    div_load     = 2'b00;
    sync_restart = 1'b0;
    #12;
    check("reset", 0, obs, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ch0 N=2, ch1 N=6, then drain both
    drive(2'b00, 8'd2, 8'd6, 2'b11, 1'b0, 3'b0, 3'b0, 1);
    for (int k = 1; k <= 19; k++)
      drive((k <= 12) ? 2'b11 : 2'b00, 8'd0, 8'd0, 2'b00, 1'b0,
            (k <= 14) ? w((k - 1) % 2, 2) : 3'b0,
            (k <= 18) ? w((k - 1) % 6, 6) : 3'b0, 1);

    // 2: ch0 odd N=3, loaded together with the enable
    for (int k = 1; k <= 13; k++)
      drive((k <= 9) ? 2'b01 : 2'b00, 8'd3, 8'd0, (k == 1) ? 2'b01 : 2'b00, 1'b0,
            (k <= 12) ? w((k - 1) % 3, 3) : 3'b0, 3'b0, 2);

    // 3: N=4, load 8 mid-period, takes effect at the wrap; then drain
    for (int k = 1; k <= 13; k++)
      drive((k <= 5) ? 2'b01 : 2'b00, (k == 3) ? 8'd8 : 8'd4, 8'd0,
            (k == 1 || k == 3) ? 2'b01 : 2'b00, 1'b0,
            (k <= 4) ? w(k - 1, 4) : (k <= 12) ? w(k - 5, 8) : 3'b0, 3'b0, 3);

    // 4: ratios 0 and 1 clamp to 2
    for (int k = 1; k <= 7; k++)
      drive((k <= 4) ? 2'b01 : 2'b00, (k == 1) ? 8'd0 : 8'd1, 8'd0,
            (k <= 2) ? 2'b01 : 2'b00, 1'b0,
            (k <= 6) ? w((k - 1) % 2, 2) : 3'b0, 3'b0, 4);

    // 5: N=6, disable at cnt=1 drains the full period
    for (int k = 1; k <= 7; k++)
      drive((k <= 2) ? 2'b01 : 2'b00, 8'd6, 8'd0, (k == 1) ? 2'b01 : 2'b00, 1'b0,
            (k <= 6) ? w(k - 1, 6) : 3'b0, 3'b0, 5);

    // 5b: re-enable during drain keeps phase and running
    for (int k = 1; k <= 19; k++)
      drive((k <= 2 || (k >= 5 && k <= 12)) ? 2'b01 : 2'b00, 8'd0, 8'd0, 2'b00, 1'b0,
            (k <= 18) ? w((k - 1) % 6, 6) : 3'b0, 3'b0, 6);

    // 6: skewed ch0 N=4 / ch1 N=6, sync_restart aligns both
    for (int k = 1; k <= 18; k++)
      drive((k == 1) ? 2'b10 : 2'b11, 8'd4, 8'd6,
            (k == 1) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00, (k == 5),
            (k == 1) ? 3'b0 : (k < 5) ? w(k - 2, 4) : w((k - 5) % 4, 4),
            (k < 5) ? w(k - 1, 6) : w((k - 5) % 6, 6), 7);

    // async reset in the middle of a high phase
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 8, obs, 6'b0);
    div_en = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 8'd0, 8'd0, 2'b00, 1'b0, 3'b0, 3'b0, 9);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised multi-channel integer clock divider. Successor to the fixed ÷2/÷6 write/read clock generator.
- Each channel produces a divided clock and a one-cycle tick strobe from the master clk.
- Per-channel features: runtime-programmable ratio, glitch-free ratio update, clean start/stop, and a global phase-alignment restart.
- Feeds wclk/rclk-style domain clocks to FIFO and CDC test logic.

Parameters:
- NUM_CH, 2, number of independent divider channels.
- DIV_W, 8, width of each channel's divide ratio.
- RST_DIV, 2, divide ratio loaded into every shadow and active ratio register at reset (must be ≥ 2).

Ports:
- clk  input  1  master clock
- rst_n  input  1  asynchronous active-low reset
- div_en  input  NUM_CH  per-channel run enable
- div_val  input  NUM_CH*DIV_W  per-channel ratio N; channel i uses bits [i*DIV_W +: DIV_W]
- div_load  input  NUM_CH  per-channel one-cycle pulse; captures div_val into the shadow ratio
- sync_restart  input  1  one-cycle pulse; phase-aligns all running channels
- clk_out  output  NUM_CH  divided clocks
- tick  output  NUM_CH  one-clk pulse in the last cycle of each output period
- running  output  NUM_CH  channel state is RUN or DRAIN

Behaviour:
- Interface: reset is rst_n, asynchronous, active-low; clock is clk. All state is on the clk rising edge (exception: the optional feature below).
- Reset values:
  - clk_out = 0, tick = 0, running = 0.
  - Counter cnt = 0, state = IDLE.
  - Shadow ratio and active ratio = RST_DIV.
  - Reset mid-operation forces these values immediately, with no drain.
- Ratio rules:
  - div_load[i] copies div_val slice i into shadow[i].
  - A captured value < 2 is stored as 2 (clamp), so N is always in the range 2..2^DIV_W-1.
- Active ratio N loads from the shadow only at these three points; this makes updates glitch-free:
  - the IDLE→RUN transition;
  - a wrap (cnt == N-1);
  - a sync_restart.
- If div_load and a load point fall in the same cycle, the new div_val applies immediately (bypass).
- Counting and output:
  - cnt counts 0..N-1 and wraps to 0.
  - clk_out is registered; it is 1 while cnt < H, with H = floor(N/2).
  - Result: high for H cycles, low for N-H cycles. Even N gives 50% duty; odd N gives a high phase one cycle shorter than the low phase.
  - tick = 1 exactly in the cycle cnt == N-1.
- Per-channel FSM:
  - IDLE: cnt = 0, clk_out = 0. If div_en = 1 is sampled, go to RUN on that edge with cnt <= 0 and clk_out <= 1, i.e. 1-cycle latency from enable to the first rising edge.
  - RUN: count. If div_en = 0 is sampled, go to DRAIN (output is not truncated).
  - DRAIN: keep counting. At cnt == N-1, go to IDLE (clk_out <= 0, tick asserted for that cycle). If div_en = 1 is sampled in DRAIN, return to RUN with no phase disturbance.
- sync_restart:
  - Every channel in RUN or DRAIN does cnt <= 0, clk_out <= 1, and reloads its ratio from the shadow.
  - Priority is higher than wrap and higher than div_en deassert; the state is unchanged.
  - IDLE channels ignore it.
- N = 2 gives a clk/2 output identical to the legacy ÷2 generator.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- Defined:
  - For odd N, each channel adds a negedge-clk register that delays the posedge clk_out high phase by half a cycle.
  - Output = posedge register OR negedge register, giving a high time of exactly N/2 clk periods (50% duty).
  - Even N, tick, and FSM behaviour are unchanged.
  - The negedge register also resets to 0.
- Undefined: purely posedge logic; odd-N duty is floor(N/2)/N.

Decomposition:
- Package clk_div_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - constant DIV_MIN = 2;
  - the clamp function.
- Sub-module clk_div_chan implements one channel (counter, FSM, shadow, optional negedge stage).
- clk_div_gen generates NUM_CH instances and fans out sync_restart.

Test Plan:
1. Reset, then div_load ch0 = 2 and ch1 = 6, enable both → ch0 period 2 (1 high / 1 low); ch1 period 6 (3 high / 3 low); first rising edge 1 clk after enable; one tick per period.
2. ch0 N = 3 → feature off: 1 high / 2 low. Feature on: high 1.5 clk, low 1.5 clk. tick every 3 clk in both cases.
3. ch0 running at N = 4; load 8 at cnt = 1 → current period completes at 4; next period is 8 (4 high / 4 low); no runt pulse.
4. div_val = 0 and div_val = 1 loaded → both behave as N = 2.
5. N = 6; deassert div_en at cnt = 1 → clk_out completes its 6-cycle period, tick at cnt = 5, then IDLE with clk_out = 0.
   - Repeat, reasserting div_en at cnt = 3 → output is continuous and running stays 1.
6. ch0 N = 4 and ch1 N = 6 at skewed phases; pulse sync_restart → both clk_out high on the next edge, with rising edges coinciding every 12 clk.
   - Assert rst_n = 0 mid-high phase → all outputs 0 with no clk edge required.
